// File: rtl/uart_tx_arbiter_if.sv
// Requester/Tx-engine bundle around the arbiter; master is the arbiter side,
// slave is the requesters plus the Tx engine.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           active;
  logic           err;

  modport master (
    input  req, req_data, tx_busy,
    output grant, tx_send, tx_data, active, err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  grant, tx_send, tx_data, active, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART Tx engine among N byte requesters; grant 1 clk and send 2 clks after req is sampled.
// Requesters hold req until granted; engine busy, start timeout and the inter-frame gap stall all new grants.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 16,
  parameter int START_TO   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int PW      = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] sel, sel_nxt;
  logic [PW-1:0] pick, idx;
  logic          pick_vld;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    tx_data_q, tx_data_nxt;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = ptr;
    for (int i = 0; i < N; i++) begin
      if (!pick_vld && bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    tx_data_nxt = tx_data_q;
    bus.grant   = '0;
    bus.tx_send = 1'b0;
    bus.err     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          sel_nxt   = pick;
          state_nxt = LOAD;
        end
      end

      // sel was latched in IDLE, so a req dropped now is still served.
      LOAD: begin
        bus.grant = {{(N-1){1'b0}}, 1'b1} << sel;
        for (int i = 0; i < N; i++) begin
          if (sel == PW'(i)) tx_data_nxt = bus.req_data[8*i +: 8];
        end
        ptr_nxt   = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
        state_nxt = SEND;
      end

      SEND: begin
        bus.tx_send = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_BUSY;
      end

      // Busy is level-tested: an engine that is already busy counts as started.
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          bus.err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_nxt   = '0;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + 1'b1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      tx_data_q <= tx_data_nxt;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.active  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, timeout/reset sequences, and a
// randomized multi-requester run scored against a round-robin queue model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TO  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(
    .N          (N),
    .GAP_CYCLES (GAP),
    .START_TO   (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Behavioural Tx engine: after a send, waits eng_dly clocks then stays busy eng_len clocks.
  logic eng_on  = 1'b1;
  int   eng_dly = 0;
  int   eng_len = 10;
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_send && eng_on) begin
        @(posedge clk); #1;
        repeat (eng_dly) begin @(posedge clk); #1; end
        bus.tx_busy = 1'b1;
        repeat (eng_len) begin @(posedge clk); #1; end
        bus.tx_busy = 1'b0;
      end
    end
  end

  int viol = 0;
  always @(negedge clk) begin
    if (((bus.grant & (bus.grant - 1'b1)) != '0) || (bus.grant != '0 && bus.err))
      viol <= viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] dat;
    logic [N-1:0]   exp_g;
    logic [7:0]     exp_b;
  } vec_t;

  vec_t tbl [12];

  task automatic run_one(input string tag, input logic [N-1:0] r, input logic [8*N-1:0] d,
                         input logic [N-1:0] exp_g, input logic [7:0] exp_b);
    int lat, t, gcnt, scnt, gap;
    logic hold_bad, seen_busy;
    logic [N-1:0] g;
    @(negedge clk);
    bus.req      = r;
    bus.req_data = d;
    lat = 0;
    g   = '0;
    while (g == '0 && lat < 50) begin
      @(negedge clk);
      lat++;
      g = bus.grant;
    end
    check({tag, " grant"}, 32'(g), 32'(exp_g));
    check({tag, " grant latency"}, lat, 1);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    check({tag, " send"}, 32'(bus.tx_send), 1);
    check({tag, " byte"}, 32'(bus.tx_data), 32'(exp_b));
    hold_bad  = 1'b0;
    seen_busy = 1'b0;
    gcnt = 0; scnt = 0; gap = 0; t = 0;
    while (bus.active && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.grant != '0) gcnt++;
      if (bus.tx_send) scnt++;
      if (bus.tx_busy) seen_busy = 1'b1;
      if (bus.tx_busy && bus.tx_data !== exp_b) hold_bad = 1'b1;
      if (!bus.tx_busy && bus.active && seen_busy) gap++;
    end
    check({tag, " frame end"}, 32'(bus.active), 0);
    check({tag, " extra grant/send"}, gcnt + scnt, 0);
    check({tag, " data hold"}, 32'(hold_bad), 0);
    check({tag, " idle after busy"}, gap, GAP + 1);
  endtask

  logic [7:0] bytes [N][$];
  int cnt [N];
  int pos [N];
  int exp_id [$];
  logic [7:0] exp_b [$];
  int obs_id [$];
  logic [7:0] obs_b [$];
  int m_ptr;

  initial begin
    int t, total, nsent, last_send, last_len, cur_len, i;

    tbl[0]  = '{4'b0001, 32'h4433_22A5, 4'b0001, 8'hA5};
    tbl[1]  = '{4'b0001, 32'h0000_005A, 4'b0001, 8'h5A};
    tbl[2]  = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22};
    tbl[3]  = '{4'b0011, 32'h0000_BBAA, 4'b0001, 8'hAA};
    tbl[4]  = '{4'b0011, 32'h0000_BBAA, 4'b0010, 8'hBB};
    tbl[5]  = '{4'b1100, 32'hDDCC_0000, 4'b0100, 8'hCC};
    tbl[6]  = '{4'b0101, 32'h00EE_00F0, 4'b0001, 8'hF0};
    tbl[7]  = '{4'b1000, 32'h7E00_0000, 4'b1000, 8'h7E};
    tbl[8]  = '{4'b1010, 32'h0100_0200, 4'b0010, 8'h02};
    tbl[9]  = '{4'b0110, 32'h00C3_3C00, 4'b0100, 8'hC3};
    tbl[10] = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44};
    tbl[11] = '{4'b1111, 32'h4433_2211, 4'b0001, 8'h11};

    bus.req      = '0;
    bus.req_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset active", 32'(bus.active), 0);
    check("reset grant", 32'(bus.grant), 0);
    check("reset tx_send", 32'(bus.tx_send), 0);
    check("reset tx_data", 32'(bus.tx_data), 0);
    check("reset err", 32'(bus.err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++)
      run_one($sformatf("vec%0d", k), tbl[k].req, tbl[k].dat, tbl[k].exp_g, tbl[k].exp_b);

    // Start timeout: engine never goes busy.
    eng_on = 1'b0;
    @(negedge clk);
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_0042;
    t = 0;
    while (bus.grant == '0 && t < 50) begin @(negedge clk); t++; end
    check("timeout grant", 32'(bus.grant), 32'h1);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    check("timeout send", 32'(bus.tx_send), 1);
    t = 0;
    while (!bus.err && t < TO + 10) begin @(negedge clk); t++; end
    check("timeout err delay", t, TO);
    @(negedge clk);
    check("timeout err pulse width", 32'(bus.err), 0);
    check("timeout back to idle", 32'(bus.active), 0);
    eng_on = 1'b1;
    run_one("after timeout", 4'b0001, 32'h0000_0043, 4'b0001, 8'h43);

    // Reset while the engine is mid-frame; pointer sits at 2 beforehand.
    @(negedge clk);
    bus.req      = 4'b0010;
    bus.req_data = 32'h0000_9900;
    t = 0;
    while (bus.grant == '0 && t < 50) begin @(negedge clk); t++; end
    check("rst setup grant", 32'(bus.grant), 32'h2);
    @(posedge clk); #1;
    bus.req = '0;
    t = 0;
    while (!bus.tx_busy && t < 50) begin @(negedge clk); t++; end
    check("rst setup busy", 32'(bus.tx_busy), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid active", 32'(bus.active), 0);
    check("rst mid tx_send", 32'(bus.tx_send), 0);
    check("rst mid tx_data", 32'(bus.tx_data), 0);
    check("rst mid grant", 32'(bus.grant), 0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (bus.tx_busy && t < 50) begin @(negedge clk); t++; end
    check("rst engine drained", 32'(bus.tx_busy), 0);
    run_one("post reset", 4'b1001, 32'h7700_0066, 4'b0001, 8'h66);
    run_one("post reset 2", 4'b1000, 32'h7700_0066, 4'b1000, 8'h77);

    // Randomized rounds: each requester has a queue of bytes, req held while non-empty.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    for (int round = 0; round < 3; round++) begin
      exp_id.delete(); exp_b.delete(); obs_id.delete(); obs_b.delete();
      total = 0;
      for (int r = 0; r < N; r++) begin
        bytes[r].delete();
        cnt[r] = $urandom_range(0, 4);
        if (r == round) cnt[r] = cnt[r] + 1;
        pos[r] = 0;
        for (int k = 0; k < cnt[r]; k++) bytes[r].push_back(8'($urandom_range(0, 255)));
        total += cnt[r];
      end
      begin
        int left [N];
        int used [N];
        for (int r = 0; r < N; r++) begin left[r] = cnt[r]; used[r] = 0; end
        for (int f = 0; f < total; f++) begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (left[c] > 0) begin
              exp_id.push_back(c);
              exp_b.push_back(bytes[c][used[c]]);
              used[c]++;
              left[c]--;
              m_ptr = (c + 1) % N;
              break;
            end
          end
        end
      end

      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        bus.req[r] = (cnt[r] > 0);
        bus.req_data[8*r +: 8] = (cnt[r] > 0) ? bytes[r][0] : 8'h00;
      end
      nsent = 0; t = 0; last_send = -1; last_len = 0; cur_len = 0;
      while (nsent < total && t < 20000) begin
        @(negedge clk);
        t++;
        if (bus.tx_send) begin
          obs_b.push_back(bus.tx_data);
          nsent++;
          if (last_send >= 0)
            check("rnd send spacing ok", 32'(t - last_send >= last_len + GAP), 1);
          last_send = t;
          last_len  = cur_len;
        end
        if (bus.grant != '0) begin
          i = onehot_idx(bus.grant);
          obs_id.push_back(i);
          eng_dly = $urandom_range(0, 4);
          eng_len = $urandom_range(3, 12);
          cur_len = eng_len;
          @(posedge clk); #1;
          if (i >= 0) begin
            pos[i]++;
            if (pos[i] < cnt[i]) bus.req_data[8*i +: 8] = bytes[i][pos[i]];
            else                 bus.req[i] = 1'b0;
          end
        end
      end
      t = 0;
      while (bus.active && t < 200) begin @(negedge clk); t++; end
      check("rnd drained", 32'(bus.active), 0);
      check("rnd grant count", obs_id.size(), exp_id.size());
      check("rnd send count", obs_b.size(), exp_b.size());
      for (int k = 0; k < exp_id.size() && k < obs_id.size() && k < obs_b.size(); k++) begin
        check($sformatf("rnd%0d frame%0d requester", round, k), obs_id[k], exp_id[k]);
        check($sformatf("rnd%0d frame%0d byte", round, k), 32'(obs_b[k]), 32'(exp_b[k]));
      end
      bus.req = '0;
    end

    repeat (2) @(negedge clk);
    check("grant onehot / err exclusive", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
